// File: rtl/piu_bdupdate_ctrl_if.sv
// Signal bundle for piu_bdupdate_ctrl: front-end start/PP lists, static-info read port,
// dynamic boundary decoder hookup and boundary-memory write port.
interface piu_bdupdate_ctrl_if #(
    parameter int NUM_PCH     = 8,
    parameter int PCHADDR_BW  = 3,
    parameter int PCHSTAT_BW  = 8,
    parameter int FACEBD_BW   = 2,
    parameter int CORNERBD_BW = 2
);
    logic                       start;
    logic [NUM_PCH*2-1:0]       pchpp_list_reg0_in;
    logic [NUM_PCH*2-1:0]       pchpp_list_reg1_in;
    logic                       busy;
    logic                       done;
    logic                       stat_rd_en;
    logic [PCHADDR_BW-1:0]      stat_rd_addr;
    logic [PCHSTAT_BW-1:0]      stat_rd_data;
    logic [PCHADDR_BW-1:0]      dec_pchidx;
    logic [PCHSTAT_BW-1:0]      dec_pchinfo_static;
    logic [NUM_PCH*2-1:0]       dec_pchpp_list_reg0;
    logic [NUM_PCH*2-1:0]       dec_pchpp_list_reg1;
    logic [4*FACEBD_BW-1:0]     dec_wr_facebd;
    logic [4*CORNERBD_BW-1:0]   dec_wr_cornerbd;
    logic                       bd_wr_en;
    logic [PCHADDR_BW-1:0]      bd_wr_addr;
    logic [4*FACEBD_BW-1:0]     bd_wr_facebd;
    logic [4*CORNERBD_BW-1:0]   bd_wr_cornerbd;

    // Controller view.
    modport master (
        input  start, pchpp_list_reg0_in, pchpp_list_reg1_in, stat_rd_data,
               dec_wr_facebd, dec_wr_cornerbd,
        output busy, done, stat_rd_en, stat_rd_addr, dec_pchidx, dec_pchinfo_static,
               dec_pchpp_list_reg0, dec_pchpp_list_reg1, bd_wr_en, bd_wr_addr,
               bd_wr_facebd, bd_wr_cornerbd
    );

    // Front-end / memories / decoder view.
    modport slave (
        output start, pchpp_list_reg0_in, pchpp_list_reg1_in, stat_rd_data,
               dec_wr_facebd, dec_wr_cornerbd,
        input  busy, done, stat_rd_en, stat_rd_addr, dec_pchidx, dec_pchinfo_static,
               dec_pchpp_list_reg0, dec_pchpp_list_reg1, bd_wr_en, bd_wr_addr,
               bd_wr_facebd, bd_wr_cornerbd
    );
endinterface

// File: rtl/piu_bdupdate_ctrl.sv
// Boundary-table refresh sequencer: sweeps all patches through the dynamic boundary decoder.
// Optional macro PIU_BDUPD_SKIPSTAT_EN: skip rewriting non-active patch types after the first sweep.
module piu_bdupdate_ctrl #(
    parameter int NUM_PCH     = 8,
    parameter int PCHADDR_BW  = 3,
    parameter int PCHSTAT_BW  = 8,
    parameter int FACEBD_BW   = 2,
    parameter int CORNERBD_BW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    piu_bdupdate_ctrl_if.master bus
);
    localparam logic [PCHADDR_BW-1:0] LAST_IDX = PCHADDR_BW'(NUM_PCH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [PCHADDR_BW-1:0]   cnt_q, cnt_d;
    logic                    pending_q;
    logic [NUM_PCH*2-1:0]    shadow0_q, shadow1_q;
    logic                    s1_vld_q;
    logic                    s2_vld_q;
    logic                    slot_wr;
    logic                    last_wr;
    logic                    rerun;

    // The last write of a sweep ends DRAIN; a queued or coincident start turns it into a rerun.
    assign last_wr = (state_q == DRAIN) && s2_vld_q && (bus.bd_wr_addr == LAST_IDX);
    assign rerun   = last_wr && (bus.start || pending_q);

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = last_wr;
    assign bus.stat_rd_en   = (state_q == SWEEP);
    assign bus.stat_rd_addr = cnt_q;
    // Read data lands in the stage-1 cycle, so it is forwarded to the decoder there.
    assign bus.dec_pchinfo_static = s1_vld_q ? bus.stat_rd_data : '0;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    state_d = rerun ? SWEEP : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Active snapshot only changes when a sweep is launched; the shadow absorbs starts while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dec_pchpp_list_reg0 <= '0;
            bus.dec_pchpp_list_reg1 <= '0;
            shadow0_q               <= '0;
            shadow1_q               <= '0;
            pending_q               <= 1'b0;
        end else begin
            if ((state_q == IDLE) && bus.start) begin
                bus.dec_pchpp_list_reg0 <= bus.pchpp_list_reg0_in;
                bus.dec_pchpp_list_reg1 <= bus.pchpp_list_reg1_in;
            end else if (rerun) begin
                bus.dec_pchpp_list_reg0 <= bus.start ? bus.pchpp_list_reg0_in : shadow0_q;
                bus.dec_pchpp_list_reg1 <= bus.start ? bus.pchpp_list_reg1_in : shadow1_q;
            end
            if (bus.busy && bus.start) begin
                shadow0_q <= bus.pchpp_list_reg0_in;
                shadow1_q <= bus.pchpp_list_reg1_in;
            end
            if (rerun) begin
                pending_q <= 1'b0;
            end else if (bus.busy && bus.start) begin
                pending_q <= 1'b1;
            end
        end
    end

`ifdef PIU_BDUPD_SKIPSTAT_EN
    localparam int                    PCHTYPE_BW  = 3;
    localparam logic [PCHTYPE_BW-1:0] PCHTYPE_AW  = 3'd1;
    localparam logic [PCHTYPE_BW-1:0] PCHTYPE_AE  = 3'd2;
    localparam logic [PCHTYPE_BW-1:0] PCHTYPE_AC  = 3'd3;
    localparam logic [PCHTYPE_BW-1:0] PCHTYPE_AWE = 3'd4;

    logic                  first_done_q;
    logic [PCHTYPE_BW-1:0] pchtype;

    assign pchtype = bus.dec_pchinfo_static[PCHSTAT_BW-1 -: PCHTYPE_BW];
    // Static patch types keep their first-sweep boundaries; the slot still consumes its cycle.
    assign slot_wr = s1_vld_q &&
                     (!first_done_q ||
                      (pchtype inside {PCHTYPE_AW, PCHTYPE_AE, PCHTYPE_AC, PCHTYPE_AWE}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_done_q <= 1'b0;
        end else if (last_wr) begin
            first_done_q <= 1'b1;
        end
    end
`else
    assign slot_wr = s1_vld_q;
`endif

    // Two-stage read -> decode -> write pipeline, one patch per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q           <= 1'b0;
            s2_vld_q           <= 1'b0;
            bus.dec_pchidx     <= '0;
            bus.bd_wr_en       <= 1'b0;
            bus.bd_wr_addr     <= '0;
            bus.bd_wr_facebd   <= '0;
            bus.bd_wr_cornerbd <= '0;
        end else begin
            s1_vld_q     <= bus.stat_rd_en;
            s2_vld_q     <= s1_vld_q;
            bus.bd_wr_en <= slot_wr;
            if (bus.stat_rd_en) begin
                bus.dec_pchidx <= cnt_q;
            end
            if (s1_vld_q) begin
                bus.bd_wr_addr     <= bus.dec_pchidx;
                bus.bd_wr_facebd   <= bus.dec_wr_facebd;
                bus.bd_wr_cornerbd <= bus.dec_wr_cornerbd;
            end
        end
    end
endmodule

// File: tb/tb_piu_bdupdate_ctrl.sv
// Self-checking bench for piu_bdupdate_ctrl: cycle-indexed output log compared against
// expected sweep schedules derived from start times, the static memory and the PP lists.
`timescale 1ns/1ps
module tb_piu_bdupdate_ctrl;
    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int SW   = 8;
    localparam int FB   = 2;
    localparam int CB   = 2;
    localparam int PPW  = 2 * N;
    localparam int LOGN = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    piu_bdupdate_ctrl_if #(.NUM_PCH(N), .PCHADDR_BW(AW), .PCHSTAT_BW(SW),
                           .FACEBD_BW(FB), .CORNERBD_BW(CB)) bus ();

    piu_bdupdate_ctrl #(.NUM_PCH(N), .PCHADDR_BW(AW), .PCHSTAT_BW(SW),
                        .FACEBD_BW(FB), .CORNERBD_BW(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit tb_first_done = 1'b0;

    logic [SW-1:0]     stat_mem [N];
    logic              busy_at  [LOGN];
    logic              done_at  [LOGN];
    logic              rd_en_at [LOGN];
    logic [AW-1:0]     rd_addr_at [LOGN];
    logic              wr_en_at [LOGN];
    logic [AW-1:0]     wr_addr_at [LOGN];
    logic [4*FB-1:0]   wr_face_at [LOGN];
    logic [4*CB-1:0]   wr_corner_at [LOGN];

    // Decoder stand-in: any fixed mixing of its inputs will do.
    function automatic logic [4*FB-1:0] dec_face(input logic [AW-1:0] idx, input logic [SW-1:0] info,
                                                 input logic [PPW-1:0] p0, input logic [PPW-1:0] p1);
        return info ^ p0[7:0] ^ p1[15:8] ^ {5'd0, idx};
    endfunction

    function automatic logic [4*CB-1:0] dec_corner(input logic [AW-1:0] idx, input logic [SW-1:0] info,
                                                   input logic [PPW-1:0] p0, input logic [PPW-1:0] p1);
        return {idx, 5'd0} ^ p0[15:8] ^ p1[7:0] ^ {info[3:0], info[7:4]};
    endfunction

    // Which patches a sweep is expected to write.
    function automatic logic [N-1:0] exp_mask(input bit first_done);
        logic [N-1:0] m;
        m = '1;
`ifdef PIU_BDUPD_SKIPSTAT_EN
        for (int i = 0; i < N; i++) begin
            logic [2:0] t;
            t = stat_mem[i][SW-1 -: 3];
            if (first_done && !(t inside {3'd1, 3'd2, 3'd3, 3'd4})) m[i] = 1'b0;
        end
`else
        if (first_done) m = '1;
`endif
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.stat_rd_en) bus.stat_rd_data <= stat_mem[bus.stat_rd_addr];
    end

    always_comb begin
        bus.dec_wr_facebd   = dec_face(bus.dec_pchidx, bus.dec_pchinfo_static,
                                       bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1);
        bus.dec_wr_cornerbd = dec_corner(bus.dec_pchidx, bus.dec_pchinfo_static,
                                         bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1);
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            busy_at[cyc]      = bus.busy;
            done_at[cyc]      = bus.done;
            rd_en_at[cyc]     = bus.stat_rd_en;
            rd_addr_at[cyc]   = bus.stat_rd_addr;
            wr_en_at[cyc]     = bus.bd_wr_en;
            wr_addr_at[cyc]   = bus.bd_wr_addr;
            wr_face_at[cyc]   = bus.bd_wr_facebd;
            wr_corner_at[cyc] = bus.bd_wr_cornerbd;
        end
    end

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic do_start(input logic [PPW-1:0] l0, input logic [PPW-1:0] l1, output int e0);
        @(negedge clk);
        bus.start              = 1'b1;
        bus.pchpp_list_reg0_in = l0;
        bus.pchpp_list_reg1_in = l1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
    endtask

    // Expected schedule from start edge e0: read k in slot k, write k in slot k+2, done in slot N+1.
    task automatic check_sweep(input int e0, input logic [PPW-1:0] s0, input logic [PPW-1:0] s1,
                               input logic [N-1:0] wmask, input string tag);
        for (int k = 0; k < N + 2; k++) begin
            int c;
            bit er, ew;
            c  = e0 + k;
            er = (k < N);
            ew = (k >= 2) && wmask[(k >= 2) ? k - 2 : 0];
            checks++;
            if (rd_en_at[c] !== er) begin
                errors++;
                $display("FAIL %s rd_en slot %0d got %b exp %b", tag, k, rd_en_at[c], er);
            end
            if (er) begin
                checks++;
                if (rd_addr_at[c] !== AW'(k)) begin
                    errors++;
                    $display("FAIL %s rd_addr slot %0d got %0d exp %0d", tag, k, rd_addr_at[c], k);
                end
            end
            checks++;
            if (wr_en_at[c] !== ew) begin
                errors++;
                $display("FAIL %s wr_en slot %0d got %b exp %b", tag, k, wr_en_at[c], ew);
            end
            if (ew) begin
                logic [AW-1:0]   ea;
                logic [4*FB-1:0] ef;
                logic [4*CB-1:0] ec;
                ea = AW'(k - 2);
                ef = dec_face(ea, stat_mem[k - 2], s0, s1);
                ec = dec_corner(ea, stat_mem[k - 2], s0, s1);
                checks++;
                if (wr_addr_at[c] !== ea || wr_face_at[c] !== ef || wr_corner_at[c] !== ec) begin
                    errors++;
                    $display("FAIL %s wr_data slot %0d got a%0d f%h c%h exp a%0d f%h c%h", tag, k,
                             wr_addr_at[c], wr_face_at[c], wr_corner_at[c], ea, ef, ec);
                end
            end
            checks++;
            if (done_at[c] !== (k == N + 1)) begin
                errors++;
                $display("FAIL %s done slot %0d got %b exp %b", tag, k, done_at[c], (k == N + 1));
            end
            checks++;
            if (busy_at[c] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy slot %0d got %b exp 1", tag, k, busy_at[c]);
            end
        end
    endtask

    task automatic check_busy_low(input int c, input string tag);
        checks++;
        if (busy_at[c] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after got %b exp 0", tag, busy_at[c]);
        end
    endtask

    task automatic check_quiet(input string tag);
        logic [SW*2+AW*2+PPW*2+4*FB+4*CB+5:0] all;
        all = {bus.busy, bus.done, bus.stat_rd_en, bus.stat_rd_addr, bus.dec_pchidx,
               bus.dec_pchinfo_static, bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1,
               bus.bd_wr_en, bus.bd_wr_addr, bus.bd_wr_facebd, bus.bd_wr_cornerbd, 3'b000};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero got %h exp 0", tag, all);
        end
        checks++;
        if (bus.bd_wr_en !== 1'b0 || bus.stat_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s enables got wr%b rd%b exp 0", tag, bus.bd_wr_en, bus.stat_rd_en);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        tb_first_done = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("idle_after_reset");
    endtask

    task automatic test_single_sweep();
        logic [PPW-1:0] a0, a1;
        int e0;
        a0 = PPW'($urandom);
        a1 = PPW'($urandom);
        do_start(a0, a1, e0);
        wait_cyc(e0 + N + 3);
        check_sweep(e0, a0, a1, exp_mask(tb_first_done), "single");
        check_busy_low(e0 + N + 2, "single");
        tb_first_done = 1'b1;
    endtask

    task automatic test_snapshot_hold();
        logic [PPW-1:0] a0, a1;
        int e0;
        a0 = PPW'($urandom);
        a1 = PPW'($urandom);
        do_start(a0, a1, e0);
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.dec_pchpp_list_reg0 !== a0 || bus.dec_pchpp_list_reg1 !== a1) begin
                errors++;
                $display("FAIL hold snapshot step %0d got %h/%h exp %h/%h", k,
                         bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1, a0, a1);
            end
            bus.pchpp_list_reg0_in = PPW'($urandom);
            bus.pchpp_list_reg1_in = PPW'($urandom);
        end
        wait_cyc(e0 + N + 3);
        check_sweep(e0, a0, a1, exp_mask(tb_first_done), "hold");
        check_busy_low(e0 + N + 2, "hold");
        tb_first_done = 1'b1;
    endtask

    task automatic test_double_start();
        logic [PPW-1:0] a0, a1, b0, b1, c0, c1;
        int e0, ex, er;
        a0 = PPW'($urandom); a1 = PPW'($urandom);
        b0 = PPW'($urandom); b1 = PPW'($urandom);
        c0 = PPW'($urandom); c1 = PPW'($urandom);
        do_start(a0, a1, e0);
        wait_cyc(e0 + 2);
        do_start(c0, c1, ex);
        wait_cyc(e0 + 4);
        do_start(b0, b1, ex);
        wait_cyc(e0 + N);
        checks++;
        if (bus.dec_pchpp_list_reg0 !== a0 || bus.dec_pchpp_list_reg1 !== a1) begin
            errors++;
            $display("FAIL double active_mid got %h/%h exp %h/%h",
                     bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1, a0, a1);
        end
        er = e0 + N + 2;
        wait_cyc(er + 1);
        checks++;
        if (bus.dec_pchpp_list_reg0 !== b0 || bus.dec_pchpp_list_reg1 !== b1) begin
            errors++;
            $display("FAIL double active_rerun got %h/%h exp %h/%h",
                     bus.dec_pchpp_list_reg0, bus.dec_pchpp_list_reg1, b0, b1);
        end
        wait_cyc(er + N + 3);
        check_sweep(e0, a0, a1, exp_mask(tb_first_done), "double_first");
        check_sweep(er, b0, b1, exp_mask(1'b1), "double_rerun");
        check_busy_low(er + N + 2, "double");
        tb_first_done = 1'b1;
    endtask

    task automatic test_start_on_done();
        logic [PPW-1:0] a0, a1, b0, b1;
        int e0, er;
        a0 = PPW'($urandom); a1 = PPW'($urandom);
        b0 = PPW'($urandom); b1 = PPW'($urandom);
        do_start(a0, a1, e0);
        wait_cyc(e0 + N);
        do_start(b0, b1, er);
        checks++;
        if (er !== e0 + N + 2) begin
            errors++;
            $display("FAIL on_done start_edge got %0d exp %0d", er - e0, N + 2);
        end
        wait_cyc(er + N + 3);
        check_sweep(e0, a0, a1, exp_mask(tb_first_done), "on_done_first");
        check_sweep(er, b0, b1, exp_mask(1'b1), "on_done_rerun");
        check_busy_low(er + N + 2, "on_done");
        tb_first_done = 1'b1;
    endtask

    task automatic test_reset_mid_sweep();
        logic [PPW-1:0] a0, a1;
        int e0, rel, nw, nd;
        a0 = PPW'($urandom); a1 = PPW'($urandom);
        do_start(a0, a1, e0);
        wait_cyc(e0 + 4);
        rst_n = 1'b0;
        tb_first_done = 1'b0;
        #1;
        check_quiet("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(rel + 12);
        nw = 0;
        nd = 0;
        for (int c = rel; c < rel + 12; c++) begin
            nw += int'(wr_en_at[c]);
            nd += int'(done_at[c]) + int'(busy_at[c]);
        end
        checks++;
        if (nw !== 0 || nd !== 0) begin
            errors++;
            $display("FAIL mid_reset activity_after_release got wr%0d busy/done%0d exp 0", nw, nd);
        end
        a0 = PPW'($urandom); a1 = PPW'($urandom);
        do_start(a0, a1, e0);
        wait_cyc(e0 + N + 3);
        check_sweep(e0, a0, a1, exp_mask(tb_first_done), "post_reset");
        check_busy_low(e0 + N + 2, "post_reset");
        tb_first_done = 1'b1;
    endtask

    task automatic test_repeat_sweeps();
        logic [PPW-1:0] a0, a1;
        int e0;
        @(negedge clk);
        rst_n = 1'b0;
        tb_first_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            a0 = PPW'($urandom); a1 = PPW'($urandom);
            do_start(a0, a1, e0);
            wait_cyc(e0 + N + 3);
            check_sweep(e0, a0, a1, exp_mask(tb_first_done), (s == 0) ? "repeat_first" : "repeat_second");
            check_busy_low(e0 + N + 2, "repeat");
            tb_first_done = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start              = 1'b0;
        bus.pchpp_list_reg0_in = '0;
        bus.pchpp_list_reg1_in = '0;
        for (int i = 0; i < N; i++) stat_mem[i] = SW'($urandom);
        stat_mem[2][SW-1 -: 3] = 3'd0;
        stat_mem[3][SW-1 -: 3] = 3'd1;
        test_reset();
        test_single_sweep();
        test_snapshot_hold();
        test_double_start();
        test_start_on_done();
        test_reset_mid_sweep();
        test_repeat_sweeps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piu_bdupdate_ctrl.md
# piu_bdupdate_ctrl

Sequencer that refreshes the per-patch boundary table of the PIU by sweeping every patch index through the dynamic boundary decoder. On each `start` it snapshots the Pauli-product lists, reads each patch's static info from the static-info memory, drives the decoder's inputs and writes the returned face/corner boundaries into the boundary memory. It sustains one patch per cycle. It sits between the PIU's instruction front-end, which supplies `start` and the PP lists, and the boundary memory read by the measurement-schedule logic.

## Interface
Parameters (defaults from define.v):
- NUM_PCH, `NUM_PCH: number of patches swept
- PCHADDR_BW, `PCHADDR_BW: patch index width
- PCHSTAT_BW, `PCHSTAT_BW: static info word width
- FACEBD_BW / CORNERBD_BW, `FACEBD_BW / `CORNERBD_BW: boundary code widths

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: new PP lists valid on the pp inputs this cycle
- pchpp_list_reg0_in, pchpp_list_reg1_in  in  NUM_PCH*2  PP lists sampled with start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on the final boundary write of a sweep
- stat_rd_en  out  1  static-info memory read
- stat_rd_addr  out  PCHADDR_BW  read address
- stat_rd_data  in  PCHSTAT_BW  valid exactly 1 cycle after stat_rd_en
- dec_pchidx  out  PCHADDR_BW  to decoder pchidx
- dec_pchinfo_static  out  PCHSTAT_BW  to decoder pchinfo_static
- dec_pchpp_list_reg0, dec_pchpp_list_reg1  out  NUM_PCH*2  active snapshot to decoder
- dec_wr_facebd  in  4*FACEBD_BW  decoder result, combinational on dec_* outputs
- dec_wr_cornerbd  in  4*CORNERBD_BW  decoder result
- bd_wr_en  out  1  boundary memory write
- bd_wr_addr  out  PCHADDR_BW  write address (patch index)
- bd_wr_facebd  out  4*FACEBD_BW  write data
- bd_wr_cornerbd  out  4*CORNERBD_BW  write data

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE + start: copy the pp inputs to the active snapshot (dec_pchpp_list_*) and enter SWEEP with cnt=0.
- SWEEP: stat_rd_en=1, stat_rd_addr=cnt, cnt++. At cnt==NUM_PCH-1, enter DRAIN after that read issues.
- Pipeline stage 1: on the cycle after a read, register (addr, stat_rd_data) into (dec_pchidx, dec_pchinfo_static).
- Pipeline stage 2: on the next cycle, register (dec_pchidx, dec_wr_facebd, dec_wr_cornerbd) into (bd_wr_addr, bd_wr_*) and set bd_wr_en.
- DRAIN: issue no reads. Leave DRAIN when the last write issues; done=1 in that cycle.
- After DRAIN: if `pending`, load the shadow into the active snapshot, clear `pending` and re-enter SWEEP on the next cycle; otherwise go to IDLE.
- start while busy (including the done cycle): copy the pp inputs to the shadow and set `pending`.
  - A further start while pending overwrites the shadow; only one rerun is queued.
  - The active snapshot never changes mid-sweep.
- start in IDLE on the same cycle as reset release is ignored; it is honoured from the first clock edge with rst_n=1.
- The patch-type meaning is opaque to this block except under the configuration macro.

## Timing
- Reset (async assert): state IDLE, cnt=0, pending=0, all outputs 0, including snapshot and shadow.
  - Reset mid-sweep aborts the sweep; no further writes are issued.
- start sampled at edge E0.
- Reads occur in cycles 1..NUM_PCH after E0.
- Write for patch i occurs in cycle i+3, i.e. 2-cycle read-to-write latency.
- done occurs in cycle NUM_PCH+2.
- busy is high in cycles 1..NUM_PCH+2 and low in cycle NUM_PCH+3 unless a rerun is pending.
- Rerun: reads restart in cycle NUM_PCH+3, so busy stays high continuously.
- Writes are strictly in ascending address order, one per cycle, with no gaps.

## Configuration
- PIU_BDUPD_SKIPSTAT_EN defined:
  - Applies to patches whose pchtype (top PCHTYPE_BW bits of the static word) is not PCHTYPE_AW/AE/AC/AWE.
  - For these patches, bd_wr_en is suppressed on every sweep after the first completed sweep since reset. The slot still takes its cycle and the timing is unchanged.
  - `first_done` flag: set by done, cleared by reset.
- Undefined: every patch is written on every sweep; no first_done flag is implemented.

## Test plan
- NUM_PCH=8; reset, then a single start: reads at addr 0..7 in cycles 1..8; writes at addr 0..7 in cycles 3..10; done in cycle 10; busy falls in cycle 11.
- Change the pp inputs mid-sweep without start: dec_pchpp_list_* stays at the start-time values for the whole sweep.
- Two starts during a sweep carrying lists A then B: one rerun only, using list B, with reads at cycle 11 and busy high continuously through cycle 20.
- start coincident with done: the rerun begins on the next cycle with the new lists; done pulses twice, 10 cycles apart.
- rst_n asserted at cycle 5 of a sweep: all outputs go to 0 immediately; no bd_wr_en after release; a start after release gives a clean full sweep.
- PIU_BDUPD_SKIPSTAT_EN with static type X at addr 2 and AW at addr 3: the first sweep writes both; the second sweep writes addr 3 but not addr 2, with done still in cycle 10 of that sweep.
